// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared types and constants for the PWM DAC
package pwm_dac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int UNDERRUN_W = 8;
  function automatic int period_max(int width);
    return (1 << width) - 2;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: tick every DIV clk cycles; clear holds the count at 0 and suppresses tick
module pwm_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = !clear && (cnt_q == LAST);
  always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: double-buffered PWM DAC turning valid/ready magnitude samples into a fixed-period PWM
// ports: clk, rst, enable, sample_in/sample_valid/sample_ready, pwm_out, period_start, underrun_cnt, busy
// PWM_DAC_SIGNED_IN_EN: sample_in is two's complement, stored as offset binary (MSB inverted)
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic                  busy
);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(period_max(WIDTH));
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d, shadow_q, shadow_d, sample_conv;
  logic shadow_full_q, shadow_full_d, pwm_q, pwm_d, period_start_q, period_start_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic tick, boundary, accept, keep;
`ifdef PWM_DAC_SIGNED_IN_EN
  assign sample_conv = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
`else
  assign sample_conv = sample_in;
`endif
  assign accept = sample_valid && !shadow_full_q;
  assign boundary = tick && (cnt_q == CNT_MAX);
  // STOP with enable re-asserted behaves as RUN so the period carries on untouched
  assign keep = (state_q == RUN) || enable;
  pwm_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || boundary) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    duty_d = duty_q;
    shadow_d = accept ? sample_conv : shadow_q;
    shadow_full_d = shadow_full_q || accept;
    pwm_d = (state_q != IDLE) && (cnt_q < duty_q);
    period_start_d = 1'b0;
    underrun_d = underrun_q;
    if (state_q == IDLE) begin
      if (enable && shadow_full_q) begin
        state_d = RUN;
        duty_d = shadow_q;
        shadow_full_d = 1'b0;
        period_start_d = 1'b1;
      end
    end else begin
      state_d = enable ? RUN : STOP;
      if (boundary && keep) begin
        period_start_d = 1'b1;
        // promotion uses the shadow flag from the start of the cycle; a same-cycle accept waits a period
        if (shadow_full_q) begin
          duty_d = shadow_q;
          shadow_full_d = 1'b0;
        end else
          underrun_d = (&underrun_q) ? underrun_q : underrun_q + 1'b1;
      end else if (boundary) begin
        state_d = IDLE;
        pwm_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      duty_q <= '0;
      shadow_q <= '0;
      shadow_full_q <= 1'b0;
      pwm_q <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      duty_q <= duty_d;
      shadow_q <= shadow_d;
      shadow_full_q <= shadow_full_d;
      pwm_q <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q <= underrun_d;
    end
  end
  assign sample_ready = !shadow_full_q;
  assign pwm_out = pwm_q;
  assign period_start = period_start_q;
  assign underrun_cnt = underrun_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed self-checking bench for pwm_dac (DIV=1 and DIV=4 instances)
module tb_pwm_dac;
  logic clk = 1'b0, rst = 1'b1;
  logic enable = 1'b0, sample_valid = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic sample_ready, pwm_out, period_start, busy;
  logic [7:0] underrun_cnt;
  logic en4 = 1'b0, v4 = 1'b0;
  logic [7:0] s4 = 8'h00;
  logic rdy4, pwm4, ps4, busy4;
  logic [7:0] und4;
  int n_checks = 0, n_fail = 0;
  int hi, ps, rdy, hi_t;
  always #5 clk = ~clk;
  pwm_dac #(.WIDTH(8), .DIV(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .pwm_out(pwm_out), .period_start(period_start),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );
  pwm_dac #(.WIDTH(8), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .sample_in(s4), .sample_valid(v4),
    .sample_ready(rdy4), .pwm_out(pwm4), .period_start(ps4),
    .underrun_cnt(und4), .busy(busy4)
  );
  function automatic int conv(logic [7:0] x);
`ifdef PWM_DAC_SIGNED_IN_EN
    return int'({~x[7], x[6:0]});
`else
    return int'(x);
`endif
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(int n);
    hi = 0; ps = 0; rdy = 0;
    repeat (n) begin
      step();
      sample_valid = 1'b0;
      hi += int'(pwm_out);
      ps += int'(period_start);
      rdy += int'(sample_ready);
    end
  endtask
  initial begin
    step(); step();
    check("rst_pwm", pwm_out, 0);
    check("rst_ps", period_start, 0);
    check("rst_und", underrun_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sample_ready, 1);
    rst = 1'b0;
    sample_in = 8'h40; sample_valid = 1'b1;
    run(1);
    check("preload_ready", sample_ready, 0);
    check("preload_idle", busy, 0);
    enable = 1'b1;
    run(1);
    check("start_ps", period_start, 1);
    check("start_busy", busy, 1);
    sample_in = 8'h00; sample_valid = 1'b1;
    run(255);
    check("p40_high", hi, conv(8'h40));
    check("p40_ps", ps, 1);
    check("p40_ps_last", period_start, 1);
    check("p40_und", underrun_cnt, 0);
    sample_in = 8'hFF; sample_valid = 1'b1;
    run(255);
    check("p00_high", hi, conv(8'h00));
    check("p00_und", underrun_cnt, 0);
    run(255);
    check("pff_high", hi, conv(8'hFF));
    check("und1", underrun_cnt, 1);
    check("ready_held", rdy, 255);
    run(255);
    check("hold_high2", hi, conv(8'hFF));
    check("und2", underrun_cnt, 2);
    run(255);
    check("hold_high3", hi, conv(8'hFF));
    check("und3", underrun_cnt, 3);
    sample_in = 8'hA0; sample_valid = 1'b1;
    step();
    sample_in = 8'h11;
    step();
    check("full_ready", sample_ready, 0);
    sample_valid = 1'b0;
    run(253);
    check("pa0_ps", period_start, 1);
    check("pa0_und", underrun_cnt, 3);
    run(254);
    check("pa0_high", hi, conv(8'hA0));
    sample_in = 8'h30; sample_valid = 1'b1;
    run(1);
    check("edge_ps", period_start, 1);
    check("edge_und", underrun_cnt, 4);
    check("edge_ready", sample_ready, 0);
    run(255);
    check("edge_hold_high", hi, conv(8'hA0));
    check("edge_hold_und", underrun_cnt, 4);
    run(255);
    check("p30_high", hi, conv(8'h30));
    check("p30_und", underrun_cnt, 5);
    sample_in = 8'h80; sample_valid = 1'b1;
    run(255);
    check("p30b_high", hi, conv(8'h30));
    run(100);
    hi_t = hi;
    enable = 1'b0;
    run(1);
    hi_t += hi;
    check("stop_busy", busy, 1);
    run(154);
    hi_t += hi;
    check("stop_high", hi_t, conv(8'h80));
    check("stop_idle", busy, 0);
    check("stop_pwm", pwm_out, 0);
    run(10);
    check("idle_high", hi, 0);
    check("idle_busy", busy, 0);
    sample_in = 8'h90; sample_valid = 1'b1;
    run(1);
    enable = 1'b1;
    run(1);
    check("restart_ps", period_start, 1);
    run(50);
    check("mid_pwm", pwm_out, (49 < conv(8'h90)) ? 1 : 0);
    sample_in = 8'h22; sample_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; sample_valid = 1'b0;
    check("mrst_pwm", pwm_out, 0);
    check("mrst_ps", period_start, 0);
    check("mrst_und", underrun_cnt, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", sample_ready, 1);
    run(5);
    check("mrst_stay_idle", busy, 0);
    enable = 1'b0;
    s4 = 8'h10; v4 = 1'b1;
    step();
    v4 = 1'b0; en4 = 1'b1;
    step();
    check("div4_start_ps", ps4, 1);
    hi = 0; ps = 0;
    for (int i = 0; i < 1020; i++) begin
      step();
      hi += int'(pwm4);
      ps += int'(ps4);
    end
    check("div4_high", hi, 4 * conv(8'h10));
    check("div4_ps", ps, 1);
    check("div4_ps_last", ps4, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
